// File: rtl/mux_pkg.sv
// Shared constants for the two-input selector and its users.
package mux_pkg;

  // Select encodings: which operand the select bit picks.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Width used when an instance does not override it.
  localparam int MUX_WIDTH_DEFAULT = 1;

endpackage : mux_pkg

// File: rtl/mux_2to1_core.sv
// Purely combinational two-input selector: y = s ? b : a.
module mux_2to1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Conditional operator, not if/else: an unknown select then merges a and b
  // bitwise (agreeing bits pass, differing bits go X) instead of hiding the X.
  assign y = (s == SEL_B) ? b : a;

endmodule : mux_2to1_core

// File: rtl/mux_2to1.sv
// Two-input selector with a combinational output and a registered copy of
// the selected value plus the select that produced it.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             s_q
);

  mux_2to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (a),
    .b (b),
    .s (s),
    .y (y)
  );

  // Register stage: reset clears, enable loads the current selection, else hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      y_q <= '0;
      s_q <= SEL_A;
    end else if (en) begin
      y_q <= y;
      s_q <= s;
    end
  end

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: one WIDTH=1 instance for the exhaustive
// combinational sweep and reset check, one WIDTH=8 instance for the register
// stage sequences.
module tb_mux_2to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 1 instance
  logic       rst1, s1, en1, s_q1;
  logic [0:0] a1, b1, y1, y_q1;

  // WIDTH = 8 instance
  logic       rst8, s8, en8, s_q8;
  logic [7:0] a8, b8, y8, y_q8;

  mux_2to1 #(.WIDTH(1)) dut1 (
    .clk (clk), .rst (rst1), .a (a1), .b (b1), .s (s1), .en (en1),
    .y (y1), .y_q (y_q1), .s_q (s_q1)
  );

  mux_2to1 #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst8), .a (a8), .b (b8), .s (s8), .en (en8),
    .y (y8), .y_q (y_q8), .s_q (s_q8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Combinational vector: inputs and the expected y.
  typedef struct {
    logic a;
    logic b;
    logic s;
    logic y;
  } comb_vec_t;

  // Registered vector: inputs, expected y, and expected y_q/s_q after the edge.
  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] y;
    logic [7:0] y_q;
    logic       s_q;
  } reg_vec_t;

  typedef struct {
    logic [7:0] y_q;
    logic       s_q;
  } reg_exp_t;

  reg_exp_t sb_q[$];

  comb_vec_t comb_tbl[8];
  reg_vec_t  reg_tbl[11];

  initial begin
    reg_exp_t e;

    comb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    comb_tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    comb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    comb_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    comb_tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    comb_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    comb_tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1};
    comb_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    //               rst   en    a      b      s     y      y_q    s_q
    reg_tbl[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0}; // rst beats en
    reg_tbl[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b0};
    reg_tbl[2]  = '{1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'hA5, 8'hA5, 1'b0};
    reg_tbl[3]  = '{1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 8'h3C, 8'h3C, 1'b1};
    reg_tbl[4]  = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 8'h11, 8'h3C, 1'b1}; // hold
    reg_tbl[5]  = '{1'b0, 1'b0, 8'h33, 8'h44, 1'b1, 8'h44, 8'h3C, 1'b1};
    reg_tbl[6]  = '{1'b0, 1'b0, 8'h55, 8'h66, 1'b0, 8'h55, 8'h3C, 1'b1};
    reg_tbl[7]  = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 8'h02, 8'h00, 1'b0}; // mid-run reset
    reg_tbl[8]  = '{1'b1, 1'b0, 8'h01, 8'h02, 1'b1, 8'h02, 8'h00, 1'b0};
    reg_tbl[9]  = '{1'b0, 1'b0, 8'h77, 8'h88, 1'b1, 8'h88, 8'h00, 1'b0}; // en low past release
    reg_tbl[10] = '{1'b0, 1'b1, 8'h77, 8'h88, 1'b1, 8'h88, 8'h88, 1'b1};

    rst1 = 1'b1; en1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    @(posedge clk); #1;
    check("reset_y_q8", y_q8, 0);
    check("reset_s_q8", s_q8, 0);
    rst1 = 1'b0; rst8 = 1'b0;

    // Exhaustive WIDTH=1 combinational sweep; en stays low so y_q must not move.
    foreach (comb_tbl[i]) begin
      a1 = comb_tbl[i].a; b1 = comb_tbl[i].b; s1 = comb_tbl[i].s;
      #1;
      check($sformatf("comb_y[%0d]", i), y1, comb_tbl[i].y);
    end
    @(posedge clk); #1;
    check("comb_hold_y_q1", y_q1, 0);

    // WIDTH=1 reset: load a 1, then reset with every other input at 1.
    a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; en1 = 1'b1;
    @(posedge clk); #1;
    check("load_y_q1", y_q1, 1);
    rst1 = 1'b1; b1 = 1'b1; s1 = 1'b1;
    #1;
    check("rst_y1_before", y1, 1);
    @(posedge clk); #1;
    check("rst_y_q1", y_q1, 0);
    check("rst_s_q1", s_q1, 0);
    check("rst_y1_after", y1, 1);
    rst1 = 1'b0; en1 = 1'b0;

    // WIDTH=8 register sequences through the scoreboard.
    foreach (reg_tbl[i]) begin
      rst8 = reg_tbl[i].rst; en8 = reg_tbl[i].en;
      a8 = reg_tbl[i].a; b8 = reg_tbl[i].b; s8 = reg_tbl[i].s;
      e.y_q = reg_tbl[i].y_q;
      e.s_q = reg_tbl[i].s_q;
      sb_q.push_back(e);
      #1;
      check($sformatf("reg_y[%0d]", i), y8, reg_tbl[i].y);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        check($sformatf("sb_empty[%0d]", i), 1, 0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("reg_y_q[%0d]", i), y_q8, e.y_q);
        check($sformatf("reg_s_q[%0d]", i), s_q8, e.s_q);
      end
    end

    // Simultaneous change of select and data right before the edge.
    en8 = 1'b1; a8 = 8'h12; b8 = 8'h34; s8 = 1'b1;
    @(negedge clk);
    a8 = 8'h56; b8 = 8'h9A; s8 = 1'b0;
    @(posedge clk); #1;
    check("late_change_y_q", y_q8, 8'h56);
    check("late_change_s_q", s_q8, 0);

    // Unknown select: bits where a and b agree must pass through.
    en8 = 1'b0; a8 = 8'hF0; b8 = 8'hF3; s8 = 1'bx;
    #1;
    check("x_sel_upper", y8[7:4], 4'hF);
    check("x_sel_bits32", y8[3:2], 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mux_2to1
